univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg.sv | 96 +++++++++
 tb/tb_univ_shift_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: load, shift/rotate with serial I/O, clear and hold,
// plus a saturating count of shift/rotate steps since the last load, clear or reset.
module univ_shift_reg #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
  localparam int                CW          = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             cnt_full
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Reserved code 3'b111 falls into the default arm, so it holds like HOLD.
  always_comb begin
    w_q_nxt   = r_q;
    w_cnt_nxt = r_cnt;
    case (mode)
      MODE_HOLD: begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
      end
      MODE_LOAD: begin
        w_q_nxt   = d;
        w_cnt_nxt = '0;
      end
      MODE_SHL: begin
        w_q_nxt   = {r_q[WIDTH-2:0], sin_lsb};
        w_cnt_nxt = w_cnt_inc;
      end
      MODE_SHR: begin
        w_q_nxt   = {sin_msb, r_q[WIDTH-1:1]};
        w_cnt_nxt = w_cnt_inc;
      end
      MODE_ROL: begin
        w_q_nxt   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_cnt_nxt = w_cnt_inc;
      end
      MODE_ROR: begin
        w_q_nxt   = {r_q[0], r_q[WIDTH-1:1]};
        w_cnt_nxt = w_cnt_inc;
      end
      MODE_CLEAR: begin
        w_q_nxt   = RESET_VALUE;
        w_cnt_nxt = '0;
      end
      default: begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= RESET_VALUE;
      r_cnt <= '0;
    end else if (en) begin
      r_q   <= w_q_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign q         = r_q;
  assign sout_msb  = r_q[WIDTH-1];
  assign sout_lsb  = r_q[0];
  assign shift_cnt = r_cnt;
  assign cnt_full  = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): the driver queues hand-computed
// register/counter values per clock, a monitor pops and compares them on the falling edge.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  localparam logic [2:0] HOLD  = 3'b000;
  localparam logic [2:0] LOAD  = 3'b001;
  localparam logic [2:0] SHL   = 3'b010;
  localparam logic [2:0] SHR   = 3'b011;
  localparam logic [2:0] ROL   = 3'b100;
  localparam logic [2:0] ROR   = 3'b101;
  localparam logic [2:0] CLR   = 3'b110;
  localparam logic [2:0] RSVD  = 3'b111;

  typedef struct {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = HOLD;
  logic [W-1:0]  d = '0;
  logic          sin_lsb = 1'b0;
  logic          sin_msb = 1'b0;
  logic [W-1:0]  q;
  logic          sout_msb;
  logic          sout_lsb;
  logic [CW-1:0] shift_cnt;
  logic          cnt_full;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb),
    .shift_cnt(shift_cnt), .cnt_full(cnt_full)
  );

  always #5 clk = ~clk;

  // Monitor: the register presents a new value every clock; check it mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic e_full;
      e = exp_q.pop_front();
      e_full = (e.cnt == CW'(W));
      n_vec++;
      if (q !== e.q || shift_cnt !== e.cnt || cnt_full !== e_full ||
          sout_msb !== e.q[W-1] || sout_lsb !== e.q[0]) begin
        n_bad++;
        $display("FAIL %s: got q=%h cnt=%0d full=%b msb=%b lsb=%b, want q=%h cnt=%0d full=%b msb=%b lsb=%b",
                 e.name, q, shift_cnt, cnt_full, sout_msb, sout_lsb,
                 e.q, e.cnt, e_full, e.q[W-1], e.q[0]);
      end
    end
  end

  task automatic apply(input string name, input logic r, input logic e_in,
                       input logic [2:0] m, input logic [W-1:0] din,
                       input logic sl, input logic sm,
                       input logic [W-1:0] eq, input int ec);
    exp_t x;
    @(negedge clk);
    rst = r; en = e_in; mode = m; d = din; sin_lsb = sl; sin_msb = sm;
    @(posedge clk);
    #1;
    x.q = eq; x.cnt = CW'(ec); x.name = name;
    exp_q.push_back(x);
  endtask

  // rst pulses high between edges but is low again at the sampling edge.
  task automatic rst_glitch(input logic [W-1:0] eq, input int ec);
    exp_t x;
    @(negedge clk);
    en = 1'b0; mode = LOAD; d = 8'hEE;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    x.q = eq; x.cnt = CW'(ec); x.name = "rst_glitch";
    exp_q.push_back(x);
  endtask

  initial begin
    apply("reset0",      1, 0, HOLD, 8'h00, 0, 0, 8'h00, 0);
    apply("load5A",      0, 1, LOAD, 8'h5A, 0, 0, 8'h5A, 0);
    apply("garbage_shl", 0, 1, SHL,  8'h00, 1, 0, 8'hB5, 1);
    apply("reset_prio",  1, 1, LOAD, 8'hFF, 1, 1, 8'h00, 0);
    apply("load33",      0, 1, LOAD, 8'h33, 0, 0, 8'h33, 0);
    rst_glitch(8'h33, 0);
    apply("en0_load",    0, 0, LOAD, 8'h77, 0, 0, 8'h33, 0);

    apply("loadA5",      0, 1, LOAD, 8'hA5, 0, 0, 8'hA5, 0);
    for (int i = 0; i < 3; i++)
      apply("en0_shl",   0, 0, SHL,  8'h00, 1, 1, 8'hA5, 0);
    apply("shl_sin1",    0, 1, SHL,  8'h00, 1, 1, 8'h4B, 1);
    apply("shr_sin0",    0, 1, SHR,  8'h00, 1, 0, 8'h25, 2);
    apply("shl_lose0",   0, 1, SHL,  8'h00, 0, 1, 8'h4A, 3);
    apply("shr_restore", 0, 1, SHR,  8'h00, 1, 0, 8'h25, 4);

    apply("load81",      0, 1, LOAD, 8'h81, 0, 0, 8'h81, 0);
    apply("rol1",        0, 1, ROL,  8'h00, 0, 0, 8'h03, 1);
    apply("rol2",        0, 1, ROL,  8'h00, 0, 0, 8'h06, 2);
    apply("rol3",        0, 1, ROL,  8'h00, 0, 0, 8'h0C, 3);
    apply("rol4",        0, 1, ROL,  8'h00, 0, 0, 8'h18, 4);
    apply("rol5",        0, 1, ROL,  8'h00, 0, 0, 8'h30, 5);
    apply("rol6",        0, 1, ROL,  8'h00, 0, 0, 8'h60, 6);
    apply("rol7",        0, 1, ROL,  8'h00, 0, 0, 8'hC0, 7);
    apply("rol8_full",   0, 1, ROL,  8'h00, 0, 0, 8'h81, 8);
    apply("ror1_sat",    0, 1, ROR,  8'h00, 0, 0, 8'hC0, 8);
    apply("ror2_sat",    0, 1, ROR,  8'h00, 0, 0, 8'h60, 8);
    apply("ror3_sat",    0, 1, ROR,  8'h00, 0, 0, 8'h30, 8);
    apply("shl_sat",     0, 1, SHL,  8'h00, 1, 0, 8'h61, 8);
    apply("hold_sat",    0, 1, HOLD, 8'h00, 0, 0, 8'h61, 8);

    apply("load3C",      0, 1, LOAD, 8'h3C, 0, 0, 8'h3C, 0);
    apply("reserved",    0, 1, RSVD, 8'hFF, 1, 1, 8'h3C, 0);
    apply("hold",        0, 1, HOLD, 8'hFF, 1, 1, 8'h3C, 0);
    apply("clear",       0, 1, CLR,  8'hFF, 1, 1, 8'h00, 0);

    apply("loadFF",      0, 1, LOAD, 8'hFF, 0, 0, 8'hFF, 0);
    apply("shl_a",       0, 1, SHL,  8'h00, 0, 0, 8'hFE, 1);
    apply("shl_b",       0, 1, SHL,  8'h00, 0, 0, 8'hFC, 2);
    apply("shl_c",       0, 1, SHL,  8'h00, 0, 0, 8'hF8, 3);
    apply("rst_mid",     1, 1, SHL,  8'h00, 1, 1, 8'h00, 0);
    apply("after_rst",   0, 1, SHR,  8'h00, 0, 1, 8'h80, 1);

    @(negedge clk);
    en = 1'b0; rst = 1'b0;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected values left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
